// File: rtl/tlut_pkg.sv
// Shared types and defaults for the tlutMul input register pipeline.
package tlut_pkg;

   localparam int N_ELEM_DEF = 16;
   localparam int W_DEF      = 8;
   localparam int DEPTH_DEF  = 2;

   typedef logic [W_DEF-1:0]          lane_t;
   typedef lane_t [N_ELEM_DEF-1:0]    vec_t;

   // Zero every lane whose mask bit is clear.
   function automatic vec_t apply_mask(input vec_t vec, input logic [N_ELEM_DEF-1:0] mask);
      vec_t res;
      for (int i = 0; i < N_ELEM_DEF; i++)
         res[i] = mask[i] ? vec[i] : '0;
      return res;
   endfunction

endpackage

// File: rtl/register_input_skid.sv
// Stage 0 of the input pipe: main register plus one-entry skid, registered ready.
module register_input_skid #(
   parameter int VEC_W = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VEC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [VEC_W-1:0] out_data
);

   logic             main_valid;
   logic             skid_valid;
   logic             ready_q;
   logic [VEC_W-1:0] main_data;
   logic [VEC_W-1:0] skid_data;
   logic             accept;
   logic             main_free;

   assign accept    = in_valid & ready_q;
   assign main_free = ~main_valid | out_ready;

   // ready_q mirrors ~skid_valid so out_ready never reaches in_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else if (main_free) begin
         if (skid_valid) begin
            main_data  <= skid_data;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
         end else begin
            main_valid <= accept;
            if (accept)
               main_data <= in_data;
         end
      end else if (accept) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
         ready_q    <= 1'b0;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/register_input_pipe.sv
// Elastic input register pipe: masked capture, skid stage, DEPTH-1 bubble-collapsing
// stages, synchronous flush and occupancy count.
module register_input_pipe
   import tlut_pkg::*;
#(
   parameter int N_ELEM = N_ELEM_DEF,
   parameter int W      = W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_ELEM*W-1:0]           in_data,
   input  logic [N_ELEM-1:0]             lane_mask,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_ELEM*W-1:0]           out_data,
   output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

   localparam int VEC_W = N_ELEM * W;
   localparam int OCC_W = $clog2(DEPTH + 2);

   logic [VEC_W-1:0] masked;
   logic [DEPTH-1:0] stg_valid;
   logic [VEC_W-1:0] stg_data [DEPTH];
   logic [DEPTH:1]   adv;
   logic [OCC_W-1:0] occ_q;
   logic             accept;
   logic             drain;

   always_comb begin
      masked = '0;
      for (int i = 0; i < N_ELEM; i++)
         if (lane_mask[i])
            masked[i*W +: W] = in_data[i*W +: W];
   end

   // adv[k]: stage k may load this edge (empty, or its own contents move on).
   always_comb begin
      logic chain;
      adv         = '0;
      chain       = out_ready;
      adv[DEPTH]  = chain;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         chain  = ~stg_valid[k] | chain;
         adv[k] = chain;
      end
   end

   register_input_skid #(
      .VEC_W(VEC_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (masked),
      .out_valid (stg_valid[0]),
      .out_ready (adv[1]),
      .out_data  (stg_data[0])
   );

   for (genvar k = 1; k < DEPTH; k++) begin : g_stage
      logic             v_q;
      logic [VEC_W-1:0] d_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
         end else if (flush) begin
            v_q <= 1'b0;
         end else if (adv[k]) begin
            v_q <= stg_valid[k-1];
            if (stg_valid[k-1])
               d_q <= stg_data[k-1];
         end
      end

      assign stg_valid[k] = v_q;
      assign stg_data[k]  = d_q;
   end

   assign out_valid = stg_valid[DEPTH-1];
   assign out_data  = stg_data[DEPTH-1];

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occ_q <= '0;
      else if (flush)
         occ_q <= '0;
      else
         occ_q <= occ_q + {{(OCC_W-1){1'b0}}, accept} - {{(OCC_W-1){1'b0}}, drain};
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_register_input_pipe.sv
// Directed bench for register_input_pipe: default geometry plus DEPTH=1 and DEPTH=4 variants.
module tb_register_input_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, flush, out_valid, out_ready;
   logic [127:0] in_data, out_data;
   logic [15:0]  lane_mask;
   logic [1:0]   occupancy;

   logic         s_in_valid, s_flush, s_out_ready;
   logic [63:0]  s_in_data;
   logic [3:0]   s_mask;
   logic         d1_in_ready, d1_out_valid, d4_in_ready, d4_out_valid;
   logic [63:0]  d1_out_data, d4_out_data;
   logic [1:0]   d1_occ;
   logic [2:0]   d4_occ;

   int n_checks = 0;
   int n_fail   = 0;

   register_input_pipe #(.N_ELEM(16), .W(8), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .lane_mask(lane_mask), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .occupancy(occupancy));

   register_input_pipe #(.N_ELEM(4), .W(16), .DEPTH(1)) dut_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d1_in_ready), .in_data(s_in_data),
      .lane_mask(s_mask), .flush(s_flush), .out_valid(d1_out_valid), .out_ready(s_out_ready),
      .out_data(d1_out_data), .occupancy(d1_occ));

   register_input_pipe #(.N_ELEM(4), .W(16), .DEPTH(4)) dut_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d4_in_ready), .in_data(s_in_data),
      .lane_mask(s_mask), .flush(s_flush), .out_valid(d4_out_valid), .out_ready(s_out_ready),
      .out_data(d4_out_data), .occupancy(d4_occ));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mask4(input logic [63:0] d, input logic [3:0] m);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[i*16 +: 16] = d[i*16 +: 16];
      return r;
   endfunction

   task automatic test_reset;
      logic [127:0] v0;
      v0 = 128'h100F0E0D_0C0B0A09_08070605_04030201;
      rst_n = 1'b0; in_valid = 1'b1; in_data = v0; lane_mask = '1; out_ready = 1'b1; flush = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_mask = '1; s_flush = 1'b0; s_out_ready = 1'b1;
      repeat (3) tick;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
      rst_n = 1'b1;
      tick;
      in_valid = 1'b0;
      n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL first_accept_occ: got %0d want 1", occupancy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_latency_early: got %b want 0", out_valid); end
      tick;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_latency: got %b want 1", out_valid); end
      n_checks++; if (out_data !== v0) begin n_fail++; $display("FAIL first_data: got %h want %h", out_data, v0); end
      n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL first_occ_moved: got %0d want 1", occupancy); end
      tick;
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++; $display("FAIL first_drain: got valid %b occ %0d want 0 0", out_valid, occupancy);
      end
   endtask

   task automatic test_stream;
      logic [127:0] q[$];
      logic [127:0] e;
      int got;
      got = 0;
      out_ready = 1'b1; lane_mask = '1;
      for (int c = 0; c <= 102; c++) begin
         n_checks++; if (out_valid !== (c >= 2 && c <= 101)) begin
            n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid, (c >= 2 && c <= 101));
         end
         if (c >= 2 && c <= 100) begin
            n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL stream_occ c=%0d: got %0d want 2", c, occupancy); end
         end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
         if (out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL stream_extra c=%0d: got %h want none", c, out_data); end
            else begin
               e = q.pop_front();
               got++;
               if (out_data !== e) begin n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, out_data, e); end
            end
         end
         in_valid = (c < 100);
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         if (in_valid && in_ready) q.push_back(in_data);
         tick;
      end
      in_valid = 1'b0;
      n_checks++; if (got != 100 || q.size() != 0) begin
         n_fail++; $display("FAIL stream_count: got %0d left %0d want 100 0", got, q.size());
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] vec [4];
      int idx;
      logic sent;
      vec[0] = {4{32'hA0A1A2A3}}; vec[1] = {4{32'hB0B1B2B3}};
      vec[2] = {4{32'hC0C1C2C3}}; vec[3] = {4{32'hD0D1D2D3}};
      out_ready = 1'b0; in_valid = 1'b1; lane_mask = '1;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_before k=%0d: got %b want 1", k, in_ready); end
         in_data = vec[k];
         tick;
      end
      in_data = vec[3];
      for (int h = 0; h < 3; h++) begin
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready h=%0d: got %b want 0", h, in_ready); end
         n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL bp_full_occ h=%0d: got %0d want 3", h, occupancy); end
         n_checks++; if (out_valid !== 1'b1 || out_data !== vec[0]) begin
            n_fail++; $display("FAIL bp_stable h=%0d: got %b %h want 1 %h", h, out_valid, out_data, vec[0]);
         end
         if (h < 2) tick;
      end
      out_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid === 1'b1) begin
            n_checks++;
            if (idx >= 4) begin n_fail++; $display("FAIL bp_extra c=%0d: got %h want none", c, out_data); end
            else if (out_data !== vec[idx]) begin n_fail++; $display("FAIL bp_order idx=%0d: got %h want %h", idx, out_data, vec[idx]); end
            idx++;
         end
         sent = in_valid && in_ready;
         tick;
         if (sent) in_valid = 1'b0;
      end
      n_checks++; if (idx != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", idx); end
   endtask

   task automatic test_mask;
      logic [127:0] d_tab [2];
      logic [127:0] e_tab [2];
      logic [15:0]  m_tab [2];
      logic found;
      d_tab[0] = {16{8'hAB}};                           m_tab[0] = 16'h00FF;
      e_tab[0] = {64'h0, {8{8'hAB}}};
      d_tab[1] = 128'h100F0E0D_0C0B0A09_08070605_04030201; m_tab[1] = 16'h8001;
      e_tab[1] = 128'h10000000_00000000_00000000_00000001;
      out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1; in_data = d_tab[t]; lane_mask = m_tab[t];
         tick;
         in_valid = 1'b0; lane_mask = '1; in_data = '1;
         found = 1'b0;
         for (int k = 0; k < 5 && !found; k++) begin
            if (out_valid === 1'b1) found = 1'b1;
            else tick;
         end
         n_checks++; if (!found) begin n_fail++; $display("FAIL mask_timeout t=%0d: got no out_valid want 1", t); end
         n_checks++; if (out_data !== e_tab[t]) begin n_fail++; $display("FAIL mask_data t=%0d: got %h want %h", t, out_data, e_tab[t]); end
         tick;
      end
   endtask

   task automatic test_flush;
      logic [127:0] p [3];
      logic seen;
      p[0] = {8{16'h1111}}; p[1] = {8{16'h2222}}; p[2] = {8{16'h3333}};
      for (int part = 0; part < 2; part++) begin
         out_ready = 1'b0; in_valid = 1'b1;
         for (int k = 0; k < part + 2; k++) begin
            in_data = p[k];
            tick;
         end
         n_checks++; if (occupancy !== 2'(part + 2)) begin n_fail++; $display("FAIL flush_pre_occ part=%0d: got %0d want %0d", part, occupancy, part + 2); end
         n_checks++; if (in_ready !== (part == 0)) begin n_fail++; $display("FAIL flush_pre_ready part=%0d: got %b want %b", part, in_ready, (part == 0)); end
         flush = 1'b1; in_data = {8{16'hEEEE}};
         tick;
         flush = 1'b0; in_valid = 1'b0;
         n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ part=%0d: got %0d want 0", part, occupancy); end
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid part=%0d: got %b want 0", part, out_valid); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready part=%0d: got %b want 1", part, in_ready); end
         n_checks++; if (out_data !== p[0]) begin n_fail++; $display("FAIL flush_data_kept part=%0d: got %h want %h", part, out_data, p[0]); end
         out_ready = 1'b1;
         seen = 1'b0;
         for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick;
         end
         n_checks++; if (seen) begin n_fail++; $display("FAIL flush_dropped part=%0d: got out_valid after flush want none", part); end
      end
   endtask

   task automatic test_async_reset;
      logic [127:0] q[$];
      logic [127:0] e;
      int got;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         tick;
      end
      #3;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
      #2;
      rst_n = 1'b1;
      tick;
      got = 0;
      for (int c = 0; c < 14; c++) begin
         if (out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL areset_extra c=%0d: got %h want none", c, out_data); end
            else begin
               e = q.pop_front();
               got++;
               if (out_data !== e) begin n_fail++; $display("FAIL areset_data c=%0d: got %h want %h", c, out_data, e); end
            end
         end
         in_valid = (c < 10);
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         if (in_valid && in_ready) q.push_back(in_data);
         tick;
      end
      in_valid = 1'b0;
      n_checks++; if (got != 10) begin n_fail++; $display("FAIL areset_count: got %0d want 10", got); end
   endtask

   task automatic test_small_configs;
      logic [63:0] q1[$], q4[$];
      logic [63:0] v, e;
      logic        p1_stall, p4_stall;
      logic [63:0] p1_data, p4_data;
      v = 64'h0004_0003_0002_0001;
      s_mask = '1; s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = v;
      tick;
      s_in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_checks++; if (d1_out_valid !== (c == 0)) begin n_fail++; $display("FAIL d1_latency c=%0d: got %b want %b", c, d1_out_valid, (c == 0)); end
         n_checks++; if (d4_out_valid !== (c == 3)) begin n_fail++; $display("FAIL d4_latency c=%0d: got %b want %b", c, d4_out_valid, (c == 3)); end
         if (c == 0) begin
            n_checks++; if (d1_out_data !== v) begin n_fail++; $display("FAIL d1_first_data: got %h want %h", d1_out_data, v); end
         end
         if (c == 3) begin
            n_checks++; if (d4_out_data !== v) begin n_fail++; $display("FAIL d4_first_data: got %h want %h", d4_out_data, v); end
         end
         tick;
      end
      p1_stall = 1'b0; p4_stall = 1'b0; p1_data = '0; p4_data = '0;
      for (int c = 0; c < 90; c++) begin
         if (c == 10) begin
            n_checks++; if (d1_occ !== 2'd2 || d1_in_ready !== 1'b0) begin
               n_fail++; $display("FAIL d1_full: got occ %0d ready %b want 2 0", d1_occ, d1_in_ready);
            end
            n_checks++; if (d4_occ !== 3'd5 || d4_in_ready !== 1'b0) begin
               n_fail++; $display("FAIL d4_full: got occ %0d ready %b want 5 0", d4_occ, d4_in_ready);
            end
         end
         s_out_ready = (c < 10) ? 1'b0 : (c % 3 != 0);
         s_in_valid  = (c < 45);
         s_in_data   = {$urandom, $urandom};
         s_mask      = 4'($urandom);
         n_checks++; if (d1_occ !== 2'(q1.size())) begin n_fail++; $display("FAIL d1_occ c=%0d: got %0d want %0d", c, d1_occ, q1.size()); end
         n_checks++; if (d4_occ !== 3'(q4.size())) begin n_fail++; $display("FAIL d4_occ c=%0d: got %0d want %0d", c, d4_occ, q4.size()); end
         if (p1_stall) begin
            n_checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== p1_data) begin
               n_fail++; $display("FAIL d1_stable c=%0d: got %b %h want 1 %h", c, d1_out_valid, d1_out_data, p1_data);
            end
         end
         if (p4_stall) begin
            n_checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== p4_data) begin
               n_fail++; $display("FAIL d4_stable c=%0d: got %b %h want 1 %h", c, d4_out_valid, d4_out_data, p4_data);
            end
         end
         if (d1_out_valid === 1'b1 && s_out_ready) begin
            n_checks++;
            if (q1.size() == 0) begin n_fail++; $display("FAIL d1_extra c=%0d: got %h want none", c, d1_out_data); end
            else begin
               e = q1.pop_front();
               if (d1_out_data !== e) begin n_fail++; $display("FAIL d1_data c=%0d: got %h want %h", c, d1_out_data, e); end
            end
         end
         if (d4_out_valid === 1'b1 && s_out_ready) begin
            n_checks++;
            if (q4.size() == 0) begin n_fail++; $display("FAIL d4_extra c=%0d: got %h want none", c, d4_out_data); end
            else begin
               e = q4.pop_front();
               if (d4_out_data !== e) begin n_fail++; $display("FAIL d4_data c=%0d: got %h want %h", c, d4_out_data, e); end
            end
         end
         if (s_in_valid && d1_in_ready) q1.push_back(mask4(s_in_data, s_mask));
         if (s_in_valid && d4_in_ready) q4.push_back(mask4(s_in_data, s_mask));
         p1_stall = d1_out_valid & ~s_out_ready; p1_data = d1_out_data;
         p4_stall = d4_out_valid & ~s_out_ready; p4_data = d4_out_data;
         tick;
      end
      s_in_valid = 1'b0;
      n_checks++; if (q1.size() != 0 || d1_occ !== 2'd0) begin n_fail++; $display("FAIL d1_drained: got left %0d occ %0d want 0 0", q1.size(), d1_occ); end
      n_checks++; if (q4.size() != 0 || d4_occ !== 3'd0) begin n_fail++; $display("FAIL d4_drained: got left %0d occ %0d want 0 0", q4.size(), d4_occ); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_mask;
      test_flush;
      test_async_reset;
      test_small_configs;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
